alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU: accepts one operation at a time over a valid/ready interface and returns a registered result plus flags (`cout`, `v`, `lt`, `eq`, `gt`). Single-cycle ops complete in one cycle. An optional iterative shift-add multiplier adds a multi-cycle op. The block sits in the EX stage of the pipelined datapath, where the hazard/stall logic uses `in_ready`/`out_valid` to stall.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥4)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept; transfer when `in_valid & in_ready`
- `op`  in  3  opcode
- `x`, `y`  in  WIDTH  operands
- `cin`  in  1  carry-in (ADD only)
- `out_valid`  out  1  result/flags valid
- `out_ready`  in  1  consumer takes result when `out_valid & out_ready`
- `result`  out  WIDTH  registered result
- `cout`, `v`, `lt`, `eq`, `gt`, `illegal`  out  1 each  registered flags

## Operation
- Opcodes:
  - 000 ADD: `x+y+cin`
  - 001 SUB: `x+~y+1`, `cin` ignored; `cout` = carry out (1 = no borrow)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: `result` = signed(x)<signed(y), zero-extended
  - 110 MUL: low WIDTH bits of unsigned product; `cout`=1 iff the high WIDTH bits are nonzero
  - 111 reserved
- `v`: signed overflow for ADD/SUB; 0 for all other ops.
- `cout`: 0 for logic ops and SLT.
- `lt`/`eq`/`gt`: signed compare of `x`,`y`. Computed for every op; exactly one is 1.
- `illegal`=1 for op 111 (and op 110 when MUL is compiled out). In that case `result`=0 and all other flags=0.
- All outputs are registered and captured on the accept edge (or on the final MUL edge). They hold stable while `out_valid & !out_ready`.
- States:
  - IDLE: `in_ready`=1.
    - Accept non-MUL → DONE.
    - Accept MUL → MUL, loading counter=WIDTH, multiplicand, multiplier, accumulator=0.
  - MUL: `in_ready`=0, `out_valid`=0. One shift-add step per cycle. When the counter reaches 0, register the result and flags → DONE.
  - DONE: `out_valid`=1; `in_ready = out_ready`.
    - `out_ready` & `in_valid`: accept the new op in the same cycle (next state per new op).
    - `out_ready` & `!in_valid` → IDLE.
    - `!out_ready` → stay in DONE.
- Operands are sampled only at accept; input changes afterwards are ignored.

## Timing
- Reset (`rst` high at an edge):
  - next state IDLE
  - `out_valid`=0, `result`=0, all flags 0
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after release
- Non-MUL latency: accepted at edge t → `out_valid` high after edge t.
- MUL latency: accepted at edge t → `out_valid` high after edge t+WIDTH.
- Throughput with `out_ready` held high: one non-MUL op per cycle (back-to-back via DONE).
- `out_valid` never drops without a handshake, except on reset.
- Reset mid-MUL or mid-DONE aborts: the result is discarded, and there is no `out_valid` pulse after reset.
- Simultaneous `out_ready` and `in_valid` in DONE: the old result retires and the new op is captured on the same edge, with no bubble.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - MUL state, counter, and shift-add datapath are compiled in.
  - op 110 behaves as above.
- `ALU_SEQ_MUL_EN` undefined:
  - No MUL state or multiplier registers.
  - op 110 completes in 1 cycle with `illegal`=1 and `result`=0.
  - Every op has latency 1.

## Test plan
All with WIDTH=16.
- ADD x=1, y=2, cin=0 → one cycle after accept: `result`=3, `cout`=0, `v`=0, `lt`=1. Then ADD x=3, y=3, cin=1 → `result`=7, `eq`=1.
- ADD 0x7FFF+0x0001 → `result`=0x8000, `v`=1, `cout`=0. ADD 0xFFFF+0x0001 → `result`=0, `cout`=1, `v`=0.
- SUB 500−200 → `result`=300, `cout`=1, `gt`=1. SUB 2−4 → `result`=0xFFFE, `cout`=0, `lt`=1.
- MUL 500×200 (`ALU_SEQ_MUL_EN` defined) → `result`=0x86A0, `cout`=1, `out_valid` at accept+16. `in_ready`=0 throughout. Undefined: `illegal`=1, `result`=0 at accept+1.
- Backpressure: hold `out_ready`=0 for 3 cycles after XOR 0x00FF^0x0F0F → `result`=0x0FF0 stable and `in_ready`=0. Then raise `out_ready` with `in_valid` high (OR 0x0001|0x0002) → `result`=0x0003 on the next cycle, no bubble.
- Assert `rst` at MUL cycle 5 → `out_valid`=0 and outputs 0 after that edge, no late result. Then op 111 → `illegal`=1, `result`=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: request side (valid/ready + operands)
// and response side (valid/ready + registered result and flags).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             v;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             illegal;

    modport master (
        output in_valid, op, x, y, cin, out_ready,
        input  in_ready, out_valid, result, cout, v, lt, eq, gt, illegal
    );

    modport slave (
        input  in_valid, op, x, y, cin, out_ready,
        output in_ready, out_valid, result, cout, v, lt, eq, gt, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result/flags; the optional iterative
// shift-add multiplier (op 110) is compiled in when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [5:0]       flags_q, flags_d;   // {cout, v, lt, eq, gt, illegal}
    logic             in_ready_c;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_next;
`endif

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_v, sub_v;
    logic             s_lt, s_eq, s_gt;
    logic [WIDTH-1:0] alu_res;
    logic [5:0]       alu_flg;

    assign add_sum = {1'b0, bus.x} + {1'b0, bus.y} + {{WIDTH{1'b0}}, bus.cin};
    assign sub_sum = {1'b0, bus.x} + {1'b0, ~bus.y} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v   = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (add_sum[WIDTH-1] != bus.x[WIDTH-1]);
    assign sub_v   = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.x[WIDTH-1]);
    assign s_lt    = $signed(bus.x) < $signed(bus.y);
    assign s_eq    = (bus.x == bus.y);
    assign s_gt    = $signed(bus.x) > $signed(bus.y);

    // Single-cycle result; op 110 lands in default and is only used when MUL is compiled out.
    always_comb begin
        alu_res = '0;
        alu_flg = {2'b00, s_lt, s_eq, s_gt, 1'b0};
        case (bus.op)
            3'b000: begin
                alu_res    = add_sum[WIDTH-1:0];
                alu_flg[5] = add_sum[WIDTH];
                alu_flg[4] = add_v;
            end
            3'b001: begin
                alu_res    = sub_sum[WIDTH-1:0];
                alu_flg[5] = sub_sum[WIDTH];
                alu_flg[4] = sub_v;
            end
            3'b010:  alu_res = bus.x & bus.y;
            3'b011:  alu_res = bus.x | bus.y;
            3'b100:  alu_res = bus.x ^ bus.y;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, s_lt};
            default: alu_flg = 6'b000001;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        in_ready_c = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        prod_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            S_IDLE: in_ready_c = 1'b1;
            S_DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d   = prod_next[WIDTH-1:0];
                    flags_d[5] = |prod_next[2*WIDTH-1:WIDTH];
                    state_d    = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            in_ready_c = 1'b0;
        end

        if (bus.in_valid && in_ready_c) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == 3'b110) begin
                // Compare flags are fixed at accept; cout is filled in on the last step.
                state_d  = S_MUL;
                result_d = '0;
                flags_d  = {2'b00, s_lt, s_eq, s_gt, 1'b0};
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, bus.x};
                mplier_d = bus.y;
                cnt_d    = CNT_W'(WIDTH);
            end else
`endif
            begin
                state_d  = S_DONE;
                result_d = alu_res;
                flags_d  = alu_flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.cout      = flags_q[5];
    assign bus.v         = flags_q[4];
    assign bus.lt        = flags_q[3];
    assign bus.eq        = flags_q[2];
    assign bus.gt        = flags_q[1];
    assign bus.illegal   = flags_q[0];
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vectors, MUL latency, backpressure,
// reset abort, back-to-back throughput and a randomized scoreboard run.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int     W   = 16;
    localparam longint MOD = longint'(1) << W;
    localparam longint HI  = MOD / 2;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cout;
        logic         v;
        logic         lt;
        logic         eq;
        logic         gt;
        logic         ill;
    } res_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: arithmetic on wide integers straight from the opcode definitions.
    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
        res_t   e;
        longint u, s, sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        e.lt = (sa < sb);
        e.eq = (sa == sb);
        e.gt = (sa > sb);
        case (op)
            3'd0: begin
                u = longint'(a) + longint'(b) + longint'(c);
                s = sa + sb + longint'(c);
                e.r = W'(u); e.cout = (u >= MOD); e.v = (s >= HI) || (s < -HI);
            end
            3'd1: begin
                u = longint'(a) + (MOD - 1 - longint'(b)) + 1;
                s = sa - sb;
                e.r = W'(u); e.cout = (u >= MOD); e.v = (s >= HI) || (s < -HI);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: e.r = (sa < sb) ? W'(1) : W'(0);
`ifdef ALU_SEQ_MUL_EN
            3'd6: begin
                u = longint'(a) * longint'(b);
                e.r = W'(u); e.cout = (u >= MOD);
            end
`endif
            default: begin
                e = '0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic res_t observed();
        res_t o;
        o.r = bus.result; o.cout = bus.cout; o.v = bus.v;
        o.lt = bus.lt; o.eq = bus.eq; o.gt = bus.gt; o.ill = bus.illegal;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, waits (bounded) for acceptance, then scrambles the operand lines.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output bit ok);
        bus.in_valid = 1'b1; bus.op = op; bus.x = a; bus.y = b; bus.cin = c;
        ok = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.in_valid = 1'b0;
        bus.x = W'($urandom);
        bus.y = W'($urandom);
        bus.cin = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = 3'd0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        n_cmp++;
        if ({bus.out_valid, observed()} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got valid=%b out=%h want all 0", bus.out_valid, observed());
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        $display("reset: ready=%b valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_directed();
        vec_t vt [10] = '{
            '{3'd0, 16'd1,     16'd2,     1'b0, 16'd3},
            '{3'd0, 16'd3,     16'd3,     1'b1, 16'd7},
            '{3'd0, 16'h7FFF,  16'h0001,  1'b0, 16'h8000},
            '{3'd0, 16'hFFFF,  16'h0001,  1'b0, 16'h0000},
            '{3'd1, 16'd500,   16'd200,   1'b1, 16'd300},
            '{3'd1, 16'd2,     16'd4,     1'b0, 16'hFFFE},
            '{3'd2, 16'hF0F0,  16'h3C3C,  1'b0, 16'h3030},
            '{3'd3, 16'h1200,  16'h0034,  1'b0, 16'h1234},
            '{3'd5, 16'h8000,  16'h0001,  1'b0, 16'h0001},
            '{3'd5, 16'd5,     16'd3,     1'b0, 16'h0000}
        };
        res_t e;
        bit   ok;
        for (int i = 0; i < 10; i++) begin
            e = model(vt[i].op, vt[i].a, vt[i].b, vt[i].c);
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].c, ok);
            n_cmp++;
            if (!ok || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_latency: got accepted=%b valid=%b want 1/1", i, ok, bus.out_valid);
            end
            n_cmp++;
            if (observed() !== e) begin
                n_fail++; $display("FAIL dir%0d_model: got {r,c,v,lt,eq,gt,il}=%h want %h", i, observed(), e);
            end
            n_cmp++;
            if (bus.result !== vt[i].r) begin
                n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, bus.result, vt[i].r);
            end
            $display("dir%0d op=%0d x=%h y=%h cin=%b -> r=%h c=%b v=%b lt=%b eq=%b gt=%b", i, vt[i].op,
                     vt[i].a, vt[i].b, vt[i].c, bus.result, bus.cout, bus.v, bus.lt, bus.eq, bus.gt);
            tick();
        end
    endtask

    task automatic test_mul();
        res_t e;
        bit   ok;
        int   bad;
        e = model(3'd6, 16'd500, 16'd200, 1'b0);
        send(3'd6, 16'd500, 16'd200, 1'b0, ok);
`ifdef ALU_SEQ_MUL_EN
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (!ok || bad != 0) begin
            n_fail++; $display("FAIL mul_busy: got accepted=%b busy_violations=%0d want 1/0", ok, bad);
        end
`else
        bad = 0;
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL mul_accept: got accepted=0 want 1");
        end
`endif
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mul_latency: got valid=%b want 1", bus.out_valid);
        end
        n_cmp++;
        if (observed() !== e) begin
            n_fail++; $display("FAIL mul_result: got {r,c,v,lt,eq,gt,il}=%h want %h", observed(), e);
        end
        $display("mul 500*200 -> r=%h cout=%b illegal=%b", bus.result, bus.cout, bus.illegal);
        tick();
    endtask

    task automatic test_backpressure();
        res_t e;
        bit   ok;
        int   bad;
        bus.out_ready = 1'b0;
        send(3'd4, 16'h00FF, 16'h0F0F, 1'b0, ok);
        n_cmp++;
        if (!ok || bus.out_valid !== 1'b1 || bus.result !== 16'h0FF0) begin
            n_fail++; $display("FAIL bp_xor: got ok=%b valid=%b r=%h want 1/1/0ff0", ok, bus.out_valid, bus.result);
        end
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 16'h0FF0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 3'd3; bus.x = 16'h0001; bus.y = 16'h0002; bus.cin = 1'b0;
        e = model(3'd3, 16'h0001, 16'h0002, 1'b0);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || observed() !== e || bus.result !== 16'h0003) begin
            n_fail++; $display("FAIL bp_no_bubble: got valid=%b out=%h want 1/%h", bus.out_valid, observed(), e);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_retire: got valid=%b want 0", bus.out_valid);
        end
        $display("backpressure: xor held 3 cycles, or -> r=%h", e.r);
    endtask

    task automatic test_reset_abort();
        res_t e;
        bit   ok;
        int   bad;
        logic [W-1:0] a, b;
`ifdef ALU_SEQ_MUL_EN
        send(3'd6, W'($urandom), W'($urandom), 1'b0, ok);
        repeat (4) tick();
`else
        bus.out_ready = 1'b0;
        send(3'd0, W'($urandom), W'($urandom), 1'b0, ok);
        tick();
`endif
        rst = 1'b1;
        tick();
        n_cmp++;
        if (!ok || {bus.out_valid, observed()} !== '0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset: got ok=%b valid=%b out=%h ready=%b want 1/0/0/0",
                               ok, bus.out_valid, observed(), bus.in_ready);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bad = 0;
        repeat (2 * W + 4) begin
            tick();
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abort_late_result: got %0d valid cycles want 0", bad);
        end
        a = W'($urandom); b = W'($urandom);
        e = model(3'd7, a, b, 1'b1);
        send(3'd7, a, b, 1'b1, ok);
        n_cmp++;
        if (!ok || bus.out_valid !== 1'b1 || observed() !== e) begin
            n_fail++; $display("FAIL abort_illegal: got valid=%b out=%h want 1/%h", bus.out_valid, observed(), e);
        end
        $display("abort: late_valids=%0d, op7 -> illegal=%b r=%h", bad, bus.illegal, bus.result);
        tick();
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   bad;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'($urandom_range(0, 5)); bus.x = W'($urandom); bus.y = W'($urandom); bus.cin = 1'($urandom);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            e = model(bus.op, bus.x, bus.y, bus.cin);
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || observed() !== e) begin
                n_fail++; $display("FAIL b2b_%0d: got valid=%b out=%h want 1/%h", i, bus.out_valid, observed(), e);
            end
            $display("b2b%0d r=%h", i, bus.result);
            bus.op = 3'($urandom_range(0, 5)); bus.x = W'($urandom); bus.y = W'($urandom); bus.cin = 1'($urandom);
            if (i == 7) bus.in_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_random();
        res_t q[$];
        res_t e;
        bit   hold;
        int   n_tx;
        hold = 1'b0;
        n_tx = 0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!hold && $urandom_range(0, 2) != 0) begin
                bus.in_valid = 1'b1; bus.op = 3'($urandom_range(0, 7));
                bus.x = W'($urandom); bus.y = W'($urandom); bus.cin = 1'($urandom);
                hold = 1'b1;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious: got result %h want none pending", observed());
                end else begin
                    e = q.pop_front();
                    if (observed() !== e) begin
                        n_fail++; $display("FAIL rnd_tx%0d: got %h want %h", n_tx, observed(), e);
                    end
                    $display("rnd tx%0d r=%h", n_tx, bus.result);
                    n_tx++;
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                q.push_back(model(bus.op, bus.x, bus.y, bus.cin));
                hold = 1'b0;
            end
            tick();
            if (!hold) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                e = q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++; $display("FAIL rnd_drain: got %h want %h", observed(), e);
                end
            end
            tick();
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL rnd_lost: got %0d results outstanding want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
